// File: rtl/fifo_status.sv
// Synchronous show-ahead FIFO with occupancy count, almost-empty/almost-full
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module fifo_status #(
    parameter int B      = 8,
    parameter int W      = 4,
    parameter int AE_LVL = 2,
    parameter int AF_LVL = 2**W - 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         flush,
    input  logic         clr_err,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W:0] DEPTH  = (W+1)'(2**W);
    localparam logic [W:0] AE_CNT = (W+1)'(AE_LVL);
    localparam logic [W:0] AF_CNT = (W+1)'(AF_LVL);

    logic [B-1:0] mem [2**W];
    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic         wr_acc;
    logic         rd_acc;
    logic         ovf_evt;
    logic         udf_evt;

    // Full and empty come from count because the pointers are equal in both cases.
    assign empty        = (count == '0);
    assign full         = (count == DEPTH);
    assign almost_empty = (count <= AE_CNT);
    assign almost_full  = (count >= AF_CNT);

    assign wr_acc  = wr & ~full;
    assign rd_acc  = rd & ~empty;
    assign ovf_evt = wr & full & ~flush;
    assign udf_evt = rd & empty & ~flush;

    assign r_data = mem[r_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else begin
            if (wr_acc) w_ptr <= w_ptr + 1'b1;
            if (rd_acc) r_ptr <= r_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only the pointers and count define
    // which words are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) mem[w_ptr] <= w_data;
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (udf_evt)      underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

endmodule
